plot_scheduler: RTL and testbench
=================================

PLOT_SCHEDULER -- requirements
Module: plot_scheduler

Interface
REQ-001 Parameter SCR_W, default 160: screen width in pixels.
REQ-002 Parameter SCR_H, default 120: screen height in pixels.
REQ-003 Parameter BG_COLOUR, default 3'b000: colour written during a clear sweep.
REQ-004 CLOCK_50  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 resetn  input  1: reset, synchronous and active-low.
REQ-006 clonke  input  1: game tick, one-cycle pulse requesting a player draw pass.
REQ-007 clear_req  input  1: one-cycle pulse requesting a full-screen clear.
REQ-008 p1, p2, p3, p4  input  15 each: player location, [14:7]=x, [6:0]=y.
REQ-009 alive  input  4: alive[i-1]=1 when player i is alive.
REQ-010 x  output  8, y  output  7, colour  output  3: pixel to vga_adapter, all registered.
REQ-011 plot  output  1: registered write strobe to vga_adapter; x/y/colour valid when plot=1.
REQ-012 busy  output  1: high whenever state is not IDLE.
REQ-013 clear_done  output  1: one-cycle pulse when a clear sweep completes.

Function
REQ-014 FSM states SHALL be IDLE, CLEAR, DRAW_P1, DRAW_P2, DRAW_P3, DRAW_P4.
REQ-015 In IDLE with pending clear (clear_req or clr_pend) the FSM SHALL enter CLEAR; else with pending tick (clonke or tick_pend) SHALL enter DRAW_P1; clear has priority when both present.
REQ-016 On entering DRAW_P1 the block SHALL snapshot p1..p4 and alive; the pass SHALL use only the snapshot.
REQ-017 Each DRAW_Pi state SHALL last exactly one cycle: output x,y of player i with plot=1 if alive bit set and x<SCR_W and y<SCR_H, otherwise plot=0; DRAW_P4 SHALL return to IDLE.
REQ-018 Player colours SHALL be p1=3'b001, p2=3'b010, p3=3'b100, p4=3'b110.
REQ-019 Outputs SHALL lag state by one cycle: clonke sampled at edge N in IDLE -> p1 pixel at plot after edge N+1, p4 pixel after edge N+4, busy low again after edge N+5.
REQ-020 CLEAR SHALL sweep raster order, x inner 0..SCR_W-1, y outer 0..SCR_H-1, one pixel per cycle, colour=BG_COLOUR, plot=1: 19200 plotted cycles for defaults.
REQ-021 Counters SHALL wrap x at SCR_W-1 to 0 with y increment; at (SCR_W-1, SCR_H-1) the FSM SHALL return to IDLE and pulse clear_done in the cycle after the final pixel is plotted.
REQ-022 clonke arriving while busy SHALL set tick_pend; multiple ticks while busy SHALL collapse to one.
REQ-023 clear_req arriving while busy SHALL set clr_pend (collapsed); clear_req during CLEAR SHALL NOT restart the sweep but SHALL queue one further clear.
REQ-024 Pending flags SHALL clear in the cycle their request is accepted; a request coincident with acceptance of the same flag SHALL be absorbed, not re-queued.
REQ-025 plot SHALL be 0 in IDLE; x, y, colour SHALL hold their last values when plot=0.
REQ-026 No combinational path SHALL exist from any input to any output.

Reset
REQ-027 With resetn=0 at a rising edge: state=IDLE, x=0, y=0, colour=0, plot=0, busy=0, clear_done=0, both pending flags=0, sweep counters=0.
REQ-028 Reset asserted mid-CLEAR or mid-DRAW SHALL abort the operation without clear_done and discard pending requests.
REQ-029 clonke/clear_req sampled in the same edge as resetn=0 SHALL be ignored.

Verification
REQ-030 All alive, p1=0x4F77, p2=0x0001: clonke pulse -> 4 consecutive plot cycles, p1 (158,119,001), p2 (0,1,010), p3, p4; busy 5 cycles.
REQ-031 alive=4'b1010: clonke -> plot high only in p2 and p4 slots; pass still 4 cycles long.
REQ-032 clear_req from IDLE -> 19200 plot cycles colour 000, first (0,0), last (159,119), clear_done one cycle later, busy then low.
REQ-033 clonke x3 during CLEAR plus clear_req once during DRAW -> after sweep exactly one draw pass, then exactly one clear; no lost or duplicate passes.
REQ-034 resetn low at sweep pixel 5000 -> next cycle plot=0, busy=0, no clear_done; subsequent clonke draws normally.
REQ-035 p3 with x=200 (out of range) -> plot=0 in p3 slot, other players unaffected.

Source files
------------

// File: rtl/plot_scheduler_if.sv
// Pixel write bus from plot_scheduler to the vga_adapter.
// x/y/colour are only meaningful in cycles where plot is high.
interface plot_scheduler_if;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;

   modport master (output x, y, colour, plot);
   modport slave  (input  x, y, colour, plot);
endinterface

// File: rtl/plot_scheduler.sv
// Arbitrates full-screen clear sweeps and per-tick player draw passes onto one
// registered pixel write port; requests arriving while busy are queued once each.
module plot_scheduler #(
   parameter int         SCR_W     = 160,
   parameter int         SCR_H     = 120,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic             CLOCK_50,
   input  logic             resetn,
   input  logic             clonke,
   input  logic             clear_req,
   input  logic [14:0]      p1,
   input  logic [14:0]      p2,
   input  logic [14:0]      p3,
   input  logic [14:0]      p4,
   input  logic [3:0]       alive,
   plot_scheduler_if.master pix,
   output logic             busy,
   output logic             clear_done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      DRAW_P1 = 3'd2,
      DRAW_P2 = 3'd3,
      DRAW_P3 = 3'd4,
      DRAW_P4 = 3'd5
   } state_t;

   localparam logic [7:0]  X_LAST = 8'(SCR_W - 1);
   localparam logic [6:0]  Y_LAST = 7'(SCR_H - 1);
   localparam logic [31:0] W_LIM  = SCR_W;
   localparam logic [31:0] H_LIM  = SCR_H;

   state_t      r_state, w_state_next;
   logic [7:0]  r_cx;
   logic [6:0]  r_cy;
   logic        r_tick_pend, r_clr_pend;
   logic [14:0] r_snap [4];
   logic [3:0]  r_snap_alive;
   logic [7:0]  r_x, w_x_next;
   logic [6:0]  r_y, w_y_next;
   logic [2:0]  r_colour, w_colour_next;
   logic        r_plot, w_plot_next;
   logic        r_busy, r_sweep_end, r_clear_done;
   logic        w_clr_req, w_tick_req, w_accept_clr, w_accept_tick;
   logic        w_sweep_last, w_draw;
   logic [1:0]  w_slot;

   function automatic logic player_ok(input logic [14:0] p, input logic a);
      return a && ({24'd0, p[14:7]} < W_LIM) && ({25'd0, p[6:0]} < H_LIM);
   endfunction

   function automatic logic [2:0] player_colour(input logic [1:0] slot);
      case (slot)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         2'd2:    return 3'b100;
         2'd3:    return 3'b110;
         default: return 3'b000;
      endcase
   endfunction

   assign w_clr_req    = clear_req | r_clr_pend;
   assign w_tick_req   = clonke | r_tick_pend;
   assign w_sweep_last = (r_cx == X_LAST) && (r_cy == Y_LAST);

   // Next-state decode and the pixel that the coming edge will register.
   always_comb begin
      w_state_next  = r_state;
      w_accept_clr  = 1'b0;
      w_accept_tick = 1'b0;
      w_draw        = 1'b0;
      w_slot        = 2'd0;
      w_x_next      = r_x;
      w_y_next      = r_y;
      w_colour_next = r_colour;
      w_plot_next   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_clr_req) begin
               w_state_next = CLEAR;
               w_accept_clr = 1'b1;
            end else if (w_tick_req) begin
               w_state_next  = DRAW_P1;
               w_accept_tick = 1'b1;
            end else begin
               w_state_next = IDLE;
            end
         end
         CLEAR: begin
            w_x_next      = r_cx;
            w_y_next      = r_cy;
            w_colour_next = BG_COLOUR;
            w_plot_next   = 1'b1;
            if (w_sweep_last) begin
               w_state_next = IDLE;
            end else begin
               w_state_next = CLEAR;
            end
         end
         DRAW_P1: begin
            w_draw = 1'b1; w_slot = 2'd0; w_state_next = DRAW_P2;
         end
         DRAW_P2: begin
            w_draw = 1'b1; w_slot = 2'd1; w_state_next = DRAW_P3;
         end
         DRAW_P3: begin
            w_draw = 1'b1; w_slot = 2'd2; w_state_next = DRAW_P4;
         end
         DRAW_P4: begin
            w_draw = 1'b1; w_slot = 2'd3; w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
      // Off-screen or dead players leave the last pixel untouched.
      if (w_draw && player_ok(r_snap[w_slot], r_snap_alive[w_slot])) begin
         w_x_next      = r_snap[w_slot][14:7];
         w_y_next      = r_snap[w_slot][6:0];
         w_colour_next = player_colour(w_slot);
         w_plot_next   = 1'b1;
      end else begin
         w_plot_next = w_plot_next;
      end
   end

   // State register, sweep counters, pending requests and the draw snapshot.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         r_state      <= IDLE;
         r_cx         <= 8'd0;
         r_cy         <= 7'd0;
         r_tick_pend  <= 1'b0;
         r_clr_pend   <= 1'b0;
         r_snap_alive <= 4'd0;
         for (int i = 0; i < 4; i++) r_snap[i] <= 15'd0;
      end else begin
         r_state <= w_state_next;
         if (w_accept_clr) begin
            r_cx <= 8'd0;
            r_cy <= 7'd0;
         end else if (r_state == CLEAR) begin
            if (r_cx == X_LAST) begin
               r_cx <= 8'd0;
               r_cy <= (r_cy == Y_LAST) ? 7'd0 : r_cy + 7'd1;
            end else begin
               r_cx <= r_cx + 8'd1;
            end
         end
         // Acceptance wins over a coincident request so it is absorbed.
         if (w_accept_tick)  r_tick_pend <= 1'b0;
         else if (clonke)    r_tick_pend <= 1'b1;
         if (w_accept_clr)   r_clr_pend  <= 1'b0;
         else if (clear_req) r_clr_pend  <= 1'b1;
         if (w_accept_tick) begin
            r_snap[0]    <= p1;
            r_snap[1]    <= p2;
            r_snap[2]    <= p3;
            r_snap[3]    <= p4;
            r_snap_alive <= alive;
         end
      end
   end

   // Registered outputs; busy also spans the cycle the last pixel is presented.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         r_x          <= 8'd0;
         r_y          <= 7'd0;
         r_colour     <= 3'd0;
         r_plot       <= 1'b0;
         r_busy       <= 1'b0;
         r_sweep_end  <= 1'b0;
         r_clear_done <= 1'b0;
      end else begin
         r_x          <= w_x_next;
         r_y          <= w_y_next;
         r_colour     <= w_colour_next;
         r_plot       <= w_plot_next;
         r_busy       <= (w_state_next != IDLE) || (r_state != IDLE);
         r_sweep_end  <= (r_state == CLEAR) && w_sweep_last;
         r_clear_done <= r_sweep_end;
      end
   end

   assign pix.x      = r_x;
   assign pix.y      = r_y;
   assign pix.colour = r_colour;
   assign pix.plot   = r_plot;
   assign busy       = r_busy;
   assign clear_done = r_clear_done;

endmodule

// File: tb/tb_plot_scheduler.sv
// Directed bench for plot_scheduler: reset, draw passes, clear sweep,
// request queueing and reset abort, with hand-computed expectations.
module tb_plot_scheduler;
   logic        CLOCK_50 = 1'b0;
   logic        resetn, clonke, clear_req;
   logic [14:0] p1, p2, p3, p4;
   logic [3:0]  alive;
   logic        busy, clear_done;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   plot_scheduler_if pix ();

   plot_scheduler #(.SCR_W(160), .SCR_H(120), .BG_COLOUR(3'b000)) dut (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .clonke     (clonke),
      .clear_req  (clear_req),
      .p1         (p1),
      .p2         (p2),
      .p3         (p3),
      .p4         (p4),
      .alive      (alive),
      .pix        (pix),
      .busy       (busy),
      .clear_done (clear_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic expect_px(input string tag, input logic pl, input logic [7:0] ex,
                            input logic [6:0] ey, input logic [2:0] ec);
      step();
      check_eq({tag, ".plot"}, 32'(pix.plot), 32'(pl));
      check_eq({tag, ".x"}, 32'(pix.x), 32'(ex));
      check_eq({tag, ".y"}, 32'(pix.y), 32'(ey));
      check_eq({tag, ".colour"}, 32'(pix.colour), 32'(ec));
      check_eq({tag, ".busy"}, 32'(busy), 32'd1);
   endtask

   task automatic pulse_tick(input string tag);
      clonke = 1'b1;
      step();
      clonke = 1'b0;
      check_eq({tag, ".busy_start"}, 32'(busy), 32'd1);
      check_eq({tag, ".plot_start"}, 32'(pix.plot), 32'd0);
   endtask

   task automatic pass_end(input string tag, input logic [7:0] hx);
      step();
      check_eq({tag, ".busy_end"}, 32'(busy), 32'd0);
      check_eq({tag, ".plot_end"}, 32'(pix.plot), 32'd0);
      check_eq({tag, ".x_hold"}, 32'(pix.x), 32'(hx));
   endtask

   task automatic run_sweep(input string tag);
      int n = 0, err = 0, c_last = -10, c_done = -1, fx = -1, fy = -1, lx = -1, ly = -1;
      logic [7:0] ex = 8'd0;
      logic [6:0] ey = 7'd0;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      check_eq({tag, ".busy_start"}, 32'(busy), 32'd1);
      for (int c = 0; c < 20000 && c_done < 0; c++) begin
         step();
         if (pix.plot) begin
            if (n == 0) begin fx = int'(pix.x); fy = int'(pix.y); end
            if (pix.x !== ex || pix.y !== ey || pix.colour !== 3'b000) err++;
            n++;
            lx = int'(pix.x); ly = int'(pix.y); c_last = c;
            if (ex == 8'd159) begin ex = 8'd0; ey = ey + 7'd1; end
            else ex = ex + 8'd1;
         end
         if (clear_done) c_done = c;
      end
      check_eq({tag, ".done_seen"}, 32'(c_done >= 0), 32'd1);
      check_eq({tag, ".count"}, 32'(n), 32'd19200);
      check_eq({tag, ".order_err"}, 32'(err), 32'd0);
      check_eq({tag, ".first_x"}, 32'(fx), 32'd0);
      check_eq({tag, ".first_y"}, 32'(fy), 32'd0);
      check_eq({tag, ".last_x"}, 32'(lx), 32'd159);
      check_eq({tag, ".last_y"}, 32'(ly), 32'd119);
      check_eq({tag, ".done_lag"}, 32'(c_done - c_last), 32'd1);
      step();
      check_eq({tag, ".busy_after"}, 32'(busy), 32'd0);
      check_eq({tag, ".done_width"}, 32'(clear_done), 32'd0);
   endtask

   initial begin
      int n_clr, n_drw, n_done, drw_wrong_phase, tail_act, injected, got5000;
      resetn = 1'b0; clonke = 1'b1; clear_req = 1'b1;
      p1 = 15'h4F77; p2 = 15'h0001; p3 = {8'd10, 7'd20}; p4 = {8'd159, 7'd0};
      alive = 4'hF;

      // Reset with requests present: requests must be ignored.
      step(); step();
      check_eq("rst.x", 32'(pix.x), 32'd0);
      check_eq("rst.y", 32'(pix.y), 32'd0);
      check_eq("rst.colour", 32'(pix.colour), 32'd0);
      check_eq("rst.plot", 32'(pix.plot), 32'd0);
      check_eq("rst.busy", 32'(busy), 32'd0);
      check_eq("rst.done", 32'(clear_done), 32'd0);
      clonke = 1'b0; clear_req = 1'b0; resetn = 1'b1;
      step(); step();
      check_eq("rst.ignored_busy", 32'(busy), 32'd0);
      check_eq("rst.ignored_plot", 32'(pix.plot), 32'd0);

      // All alive: four consecutive plotted slots.
      pulse_tick("t030");
      expect_px("t030.p1", 1'b1, 8'd158, 7'd119, 3'b001);
      expect_px("t030.p2", 1'b1, 8'd0, 7'd1, 3'b010);
      expect_px("t030.p3", 1'b1, 8'd10, 7'd20, 3'b100);
      expect_px("t030.p4", 1'b1, 8'd159, 7'd0, 3'b110);
      pass_end("t030", 8'd159);

      // Only p2 and p4 alive; dead slots hold the previous pixel.
      alive = 4'b1010;
      pulse_tick("t031");
      expect_px("t031.p1", 1'b0, 8'd159, 7'd0, 3'b110);
      expect_px("t031.p2", 1'b1, 8'd0, 7'd1, 3'b010);
      expect_px("t031.p3", 1'b0, 8'd0, 7'd1, 3'b010);
      expect_px("t031.p4", 1'b1, 8'd159, 7'd0, 3'b110);
      pass_end("t031", 8'd159);

      // p3 off-screen; p1 changed after the pass starts must not matter.
      alive = 4'hF; p3 = {8'd200, 7'd20};
      pulse_tick("t035");
      p1 = 15'h0000;
      expect_px("t035.p1", 1'b1, 8'd158, 7'd119, 3'b001);
      expect_px("t035.p2", 1'b1, 8'd0, 7'd1, 3'b010);
      expect_px("t035.p3", 1'b0, 8'd0, 7'd1, 3'b010);
      expect_px("t035.p4", 1'b1, 8'd159, 7'd0, 3'b110);
      pass_end("t035", 8'd159);
      p1 = 15'h4F77; p3 = {8'd10, 7'd20};

      run_sweep("t032");

      // Three ticks during a clear, one clear during the draw pass.
      n_clr = 0; n_drw = 0; n_done = 0; drw_wrong_phase = 0; injected = 0;
      clear_req = 1'b1;
      for (int c = 0; c < 45000 && n_done < 2; c++) begin
         step();
         clear_req = 1'b0;
         clonke = (c == 10 || c == 100 || c == 1000) ? 1'b1 : 1'b0;
         if (pix.plot && pix.colour == 3'b000) n_clr++;
         if (pix.plot && pix.colour != 3'b000) begin
            n_drw++;
            if (n_done != 1) drw_wrong_phase++;
            if (injected == 0) begin clear_req = 1'b1; injected = 1; end
         end
         if (clear_done) n_done++;
      end
      clonke = 1'b0; clear_req = 1'b0;
      tail_act = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (pix.plot || clear_done) tail_act++;
      end
      check_eq("t033.clears", 32'(n_done), 32'd2);
      check_eq("t033.clr_px", 32'(n_clr), 32'd38400);
      check_eq("t033.drw_px", 32'(n_drw), 32'd4);
      check_eq("t033.drw_phase", 32'(drw_wrong_phase), 32'd0);
      check_eq("t033.tail", 32'(tail_act), 32'd0);
      check_eq("t033.busy", 32'(busy), 32'd0);

      // Reset at sweep pixel 5000 with a tick queued.
      got5000 = 0;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      n_clr = 0;
      for (int c = 0; c < 6000 && got5000 == 0; c++) begin
         clonke = (c == 50) ? 1'b1 : 1'b0;
         step();
         if (pix.plot) n_clr++;
         if (n_clr == 5000) got5000 = 1;
      end
      clonke = 1'b0;
      check_eq("t034.reached", 32'(got5000), 32'd1);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      check_eq("t034.plot", 32'(pix.plot), 32'd0);
      check_eq("t034.busy", 32'(busy), 32'd0);
      check_eq("t034.done", 32'(clear_done), 32'd0);
      check_eq("t034.x", 32'(pix.x), 32'd0);
      tail_act = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (pix.plot || clear_done || busy) tail_act++;
      end
      check_eq("t034.quiet", 32'(tail_act), 32'd0);
      pulse_tick("t034b");
      expect_px("t034b.p1", 1'b1, 8'd158, 7'd119, 3'b001);
      expect_px("t034b.p2", 1'b1, 8'd0, 7'd1, 3'b010);
      expect_px("t034b.p3", 1'b1, 8'd10, 7'd20, 3'b100);
      expect_px("t034b.p4", 1'b1, 8'd159, 7'd0, 3'b110);
      pass_end("t034b", 8'd159);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
